// File: rtl/cu_pkg.sv
// Shared encodings for the control-unit register-access path: write-source
// selects, responder state encoding and default bus widths.
package cu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  localparam logic [1:0] ALU_PATH = 2'b00;
  localparam logic [1:0] MEM_PATH = 2'b01;
  localparam logic [1:0] UC_PATH  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    HOLD   = 2'b10
  } rsp_state_t;

endpackage

// File: rtl/reg_file_core.sv
// NUM_REGS x DATA_W register array: one synchronous write port, two registered
// read ports that return 0 for out-of-range addresses, one combinational debug port.
module reg_file_core #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic [ADDR_W-1:0] raddr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] regs [NUM_REGS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(NUM_REGS);
  endfunction

  // Reads and the write share an edge, so a read of the written address sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data_1 <= '0;
      rd_data_2 <= '0;
    end else begin
      if (we && in_range(waddr)) regs[waddr[IDX_W-1:0]] <= wdata;
      if (re) begin
        rd_data_1 <= in_range(raddr_1) ? regs[raddr_1[IDX_W-1:0]] : '0;
        rd_data_2 <= in_range(raddr_2) ? regs[raddr_2[IDX_W-1:0]] : '0;
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    if (in_range(dbg_addr)) dbg_data = regs[dbg_addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/reg_bank_responder.sv
// Register-access responder: edge-detects read/write requests, captures the op and
// source data, commits in a one-cycle ACCESS, then holds results until enables drop.
//   state  | meaning
//   IDLE   | ready for a new request (ReadyRegFlag = 1)
//   ACCESS | commit captured write / register read data
//   HOLD   | results stable; wait for a new edge or both enables low
module reg_bank_responder
  import cu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ADR_1,
  input  logic [ADDR_W-1:0] ADR_2,
  input  logic [ADDR_W-1:0] ADR_3,
  input  logic              regReadEnable,
  input  logic              regWriteEnable,
  input  logic [1:0]        Path_Type,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_valid,
  output logic              ReadyRegFlag,
  output logic              addr_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  rsp_state_t state, state_nxt;

  logic              prev_rd, prev_wr;
  logic              new_rd, new_wr;
  logic              capture, access;
  logic              cap_rd, cap_wr;
  logic [ADDR_W-1:0] cap_a1, cap_a2, cap_a3;
  logic [1:0]        cap_path;
  logic [DATA_W-1:0] cap_data, src_data;
  logic              wr_ok, op_err;

  assign new_rd = regReadEnable  & ~prev_rd;
  assign new_wr = regWriteEnable & ~prev_wr;

  always_comb begin
    case (Path_Type)
      ALU_PATH: src_data = alu_result;
      MEM_PATH: src_data = mem_data;
      UC_PATH:  src_data = write_data;
      default:  src_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (new_rd || new_wr) state_nxt = ACCESS;
      ACCESS:  state_nxt = HOLD;
      HOLD: begin
        if (new_rd || new_wr)                        state_nxt = ACCESS;
        else if (!regReadEnable && !regWriteEnable)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ReadyRegFlag = (state == IDLE);
    access       = (state == ACCESS);
    capture      = (state != ACCESS) && (new_rd || new_wr);
  end

  // Out-of-range writes and the illegal source select are dropped but still flagged.
  assign wr_ok  = cap_wr && (cap_a3 < ADDR_W'(NUM_REGS)) && (cap_path != 2'b11);
  assign op_err = (cap_rd && ((cap_a1 >= ADDR_W'(NUM_REGS)) || (cap_a2 >= ADDR_W'(NUM_REGS))))
               || (cap_wr && !wr_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_rd  <= 1'b0;
      prev_wr  <= 1'b0;
      cap_rd   <= 1'b0;
      cap_wr   <= 1'b0;
      cap_a1   <= '0;
      cap_a2   <= '0;
      cap_a3   <= '0;
      cap_path <= '0;
      cap_data <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      prev_rd  <= regReadEnable;
      prev_wr  <= regWriteEnable;
      rd_valid <= access && cap_rd;
      addr_err <= access && op_err;
      if (capture) begin
        cap_rd   <= new_rd;
        cap_wr   <= new_wr;
        cap_a1   <= ADR_1;
        cap_a2   <= ADR_2;
        cap_a3   <= ADR_3;
        cap_path <= Path_Type;
        cap_data <= src_data;
      end
    end
  end

  reg_file_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .we        (access && wr_ok),
    .waddr     (cap_a3),
    .wdata     (cap_data),
    .re        (access && cap_rd),
    .raddr_1   (cap_a1),
    .raddr_2   (cap_a2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

endmodule

// File: tb/tb_reg_bank_responder.sv
// Self-checking bench for reg_bank_responder: directed scenarios plus randomized
// transactions compared against an array-based register model.
module tb_reg_bank_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ADR_1 = '0, ADR_2 = '0, ADR_3 = '0;
  logic       regReadEnable = 1'b0, regWriteEnable = 1'b0;
  logic [1:0] Path_Type = '0;
  logic [7:0] write_data = '0, alu_result = '0, mem_data = '0;
  logic [7:0] rd_data_1, rd_data_2;
  logic       rd_valid, ReadyRegFlag, addr_err;
  logic [7:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] m [16];
  logic [7:0] exp_rd1, exp_rd2;

  reg_bank_responder dut (
    .clk(clk), .rst(rst),
    .ADR_1(ADR_1), .ADR_2(ADR_2), .ADR_3(ADR_3),
    .regReadEnable(regReadEnable), .regWriteEnable(regWriteEnable),
    .Path_Type(Path_Type), .write_data(write_data),
    .alu_result(alu_result), .mem_data(mem_data),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_valid(rd_valid), .ReadyRegFlag(ReadyRegFlag), .addr_err(addr_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    exp_rd1 = 8'h00;
    exp_rd2 = 8'h00;
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    return (a < 8'd16) ? m[a[3:0]] : 8'h00;
  endfunction

  // One complete request: capture, ACCESS, HOLD, back to IDLE; checks every phase.
  task automatic run_req(input logic rd, input logic wr, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3, input logic [1:0] path,
                         input logic [7:0] wd, input logic [7:0] alu, input logic [7:0] mem,
                         input string name);
    logic [7:0] src;
    logic       eerr;
    case (path)
      2'b00:   src = alu;
      2'b01:   src = mem;
      default: src = wd;
    endcase
    eerr = (rd && (a1 >= 8'd16 || a2 >= 8'd16)) || (wr && (a3 >= 8'd16 || path == 2'b11));
    if (rd) begin
      exp_rd1 = model_rd(a1);
      exp_rd2 = model_rd(a2);
    end
    if (wr && a3 < 8'd16 && path != 2'b11) m[a3[3:0]] = src;

    ADR_1 = a1; ADR_2 = a2; ADR_3 = a3; Path_Type = path;
    write_data = wd; alu_result = alu; mem_data = mem;
    regReadEnable = rd; regWriteEnable = wr;
    step();
    tests_run++;
    if (ReadyRegFlag !== 1'b0) begin
      tests_failed++; $display("FAIL %s ready_access got %b want 0", name, ReadyRegFlag);
    end
    regReadEnable = 1'b0; regWriteEnable = 1'b0;
    write_data = 8'($urandom); alu_result = 8'($urandom); mem_data = 8'($urandom);
    ADR_1 = 8'($urandom); ADR_2 = 8'($urandom); ADR_3 = 8'($urandom);
    step();
    tests_run++;
    if (rd_valid !== rd || addr_err !== eerr || rd_data_1 !== exp_rd1 || rd_data_2 !== exp_rd2
        || ReadyRegFlag !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s result got v=%b e=%b d1=%h d2=%h rdy=%b want v=%b e=%b d1=%h d2=%h rdy=0",
               name, rd_valid, addr_err, rd_data_1, rd_data_2, ReadyRegFlag,
               rd, eerr, exp_rd1, exp_rd2);
    end
    step();
    tests_run++;
    if (ReadyRegFlag !== 1'b1 || rd_valid !== 1'b0 || addr_err !== 1'b0
        || rd_data_1 !== exp_rd1 || rd_data_2 !== exp_rd2) begin
      tests_failed++;
      $display("FAIL %s idle got rdy=%b v=%b e=%b d1=%h d2=%h want rdy=1 v=0 e=0 d1=%h d2=%h",
               name, ReadyRegFlag, rd_valid, addr_err, rd_data_1, rd_data_2, exp_rd1, exp_rd2);
    end
    dbg_addr = a3;
    #1;
    tests_run++;
    if (dbg_data !== model_rd(a3)) begin
      tests_failed++; $display("FAIL %s dbg[%0d] got %h want %h", name, a3, dbg_data, model_rd(a3));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    #12;
    tests_run++;
    if (ReadyRegFlag !== 1'b1 || rd_valid !== 1'b0 || addr_err !== 1'b0
        || rd_data_1 !== 8'h00 || rd_data_2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs got rdy=%b v=%b e=%b d1=%h d2=%h want 1 0 0 00 00",
               ReadyRegFlag, rd_valid, addr_err, rd_data_1, rd_data_2);
    end
    // Enable already high while leaving reset must count as a request.
    ADR_3 = 8'd1; Path_Type = 2'b10; write_data = 8'hC3; regWriteEnable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step();
    tests_run++;
    if (ReadyRegFlag !== 1'b0) begin
      tests_failed++; $display("FAIL reset_exit_req ready got %b want 0", ReadyRegFlag);
    end
    regWriteEnable = 1'b0;
    step();
    step();
    m[1] = 8'hC3;
    dbg_addr = 8'd1;
    #1;
    tests_run++;
    if (dbg_data !== 8'hC3 || ReadyRegFlag !== 1'b1) begin
      tests_failed++; $display("FAIL reset_exit_write got dbg=%h rdy=%b want c3 1", dbg_data, ReadyRegFlag);
    end
  endtask

  task automatic test_write_uc();
    run_req(1'b0, 1'b1, 8'd0, 8'd0, 8'd3, 2'b10, 8'h5A, 8'h00, 8'h00, "write_uc");
  endtask

  task automatic test_read();
    run_req(1'b1, 1'b0, 8'd3, 8'd0, 8'd3, 2'b00, 8'h00, 8'hEE, 8'h00, "read_basic");
  endtask

  task automatic test_hold_write();
    ADR_1 = 8'd3; ADR_2 = 8'd0; regReadEnable = 1'b1;
    step();
    step();
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data_1 !== 8'h5A || rd_data_2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL hold_read got v=%b d1=%h d2=%h want 1 5a 00", rd_valid, rd_data_1, rd_data_2);
    end
    step();
    tests_run++;
    if (ReadyRegFlag !== 1'b0 || rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hold_stay got rdy=%b v=%b want 0 0", ReadyRegFlag, rd_valid);
    end
    ADR_3 = 8'd3; Path_Type = 2'b00; alu_result = 8'h11; regWriteEnable = 1'b1;
    step();
    alu_result = 8'h99;
    step();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data_1 !== 8'h5A || ReadyRegFlag !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_write got v=%b d1=%h rdy=%b want 0 5a 0", rd_valid, rd_data_1, ReadyRegFlag);
    end
    regReadEnable = 1'b0; regWriteEnable = 1'b0;
    step();
    m[3] = 8'h11;
    exp_rd1 = 8'h5A; exp_rd2 = 8'h00;
    dbg_addr = 8'd3;
    #1;
    tests_run++;
    if (ReadyRegFlag !== 1'b1 || dbg_data !== 8'h11) begin
      tests_failed++; $display("FAIL hold_commit got rdy=%b dbg=%h want 1 11", ReadyRegFlag, dbg_data);
    end
  endtask

  task automatic test_rw_same();
    run_req(1'b1, 1'b1, 8'd3, 8'd3, 8'd3, 2'b01, 8'h00, 8'h00, 8'h77, "rw_same_addr");
    tests_run++;
    if (exp_rd1 !== 8'h11 || rd_data_1 !== 8'h11) begin
      tests_failed++; $display("FAIL rw_old_value got %h want 11", rd_data_1);
    end
  endtask

  task automatic test_errors();
    run_req(1'b0, 1'b1, 8'd0, 8'd0, 8'd20, 2'b10, 8'hAB, 8'h00, 8'h00, "err_waddr");
    run_req(1'b0, 1'b1, 8'd0, 8'd0, 8'd4, 2'b11, 8'hAB, 8'hCD, 8'hEF, "err_path");
    run_req(1'b1, 1'b0, 8'd1, 8'd17, 8'd0, 2'b00, 8'h00, 8'h00, 8'h00, "err_raddr");
    run_req(1'b0, 1'b1, 8'd0, 8'd0, 8'd15, 2'b10, 8'h3C, 8'h00, 8'h00, "top_reg");
  endtask

  task automatic test_reset_mid_access();
    ADR_3 = 8'd5; Path_Type = 2'b10; write_data = 8'h99; regWriteEnable = 1'b1;
    step();
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    dbg_addr = 8'd5;
    #1;
    tests_run++;
    if (ReadyRegFlag !== 1'b1 || dbg_data !== 8'h00 || rd_valid !== 1'b0 || rd_data_1 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid got rdy=%b dbg=%h v=%b d1=%h want 1 00 0 00",
               ReadyRegFlag, dbg_data, rd_valid, rd_data_1);
    end
    regWriteEnable = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (rd_valid !== 1'b0 || dbg_data !== 8'h00 || ReadyRegFlag !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_release cyc %0d got v=%b dbg=%h rdy=%b want 0 00 1",
                 i, rd_valid, dbg_data, ReadyRegFlag);
      end
    end
  endtask

  task automatic test_random();
    logic rd, wr;
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) wr = 1'b1;
      run_req(rd, wr, 8'($urandom_range(0, 19)), 8'($urandom_range(0, 19)),
              8'($urandom_range(0, 19)), 2'($urandom_range(0, 3)),
              8'($urandom), 8'($urandom), 8'($urandom), "random");
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 8'(i);
      #1;
      tests_run++;
      if (dbg_data !== m[i]) begin
        tests_failed++; $display("FAIL sweep reg %0d got %h want %h", i, dbg_data, m[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_uc();
    test_read();
    test_hold_write();
    test_rw_same();
    test_errors();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
